// File: rtl/absmem_pkg.sv
// Shared definitions for the abstract-memory check sequencer:
// state encoding and default sizing.
package absmem_pkg;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_ISSUE_ENC   = 3'd1;
    localparam logic [2:0] ST_RUN_ENC     = 3'd2;
    localparam logic [2:0] ST_COMPARE_ENC = 3'd3;
    localparam logic [2:0] ST_DONE_ENC    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_ISSUE   = ST_ISSUE_ENC,
        ST_RUN     = ST_RUN_ENC,
        ST_COMPARE = ST_COMPARE_ENC,
        ST_DONE    = ST_DONE_ENC
    } state_t;

    localparam int DEFAULT_MAX_CYCLES = 16;
    localparam int DEFAULT_CW         = 5;

endpackage

// File: rtl/absmem_seq_if.sv
// Control/result bundle between the check sequencer (slave) and the
// bench/property layer plus abstract memory (master).
interface absmem_seq_if #(
    parameter int CW = absmem_pkg::DEFAULT_CW
);
    logic          start;
    logic          vlg_commit;
    logic          ila_commit;
    logic          equal;
    logic          read_assume_true;
    logic          issue;
    logic          compare;
    logic          vlg_stall;
    logic          ila_stall;
    logic          done;
    logic          pass;
    logic          timeout;
    logic          vacuous;
    logic [CW-1:0] cycle_cnt;

    modport master (
        output start, vlg_commit, ila_commit, equal, read_assume_true,
        input  issue, compare, vlg_stall, ila_stall, done, pass, timeout,
               vacuous, cycle_cnt
    );

    modport slave (
        input  start, vlg_commit, ila_commit, equal, read_assume_true,
        output issue, compare, vlg_stall, ila_stall, done, pass, timeout,
               vacuous, cycle_cnt
    );
endinterface

// File: rtl/absmem_commit_flag.sv
// Sticky per-side commit flag; its registered value doubles as the stall.
module absmem_commit_flag (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic commit,
    output logic done
);
    logic done_q;
    logic done_d;

    always_comb begin
        done_d = done_q;
        if (clr) begin
            done_d = 1'b0;
        end else if (en && commit) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;
endmodule

// File: rtl/absmem_seq.sv
// Refinement-check sequencer: arms the abstract memory, waits for both
// sides to commit (or time out), strobes compare and latches the verdict.
module absmem_seq
    import absmem_pkg::*;
#(
    parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES,
    parameter int CW         = DEFAULT_CW
) (
    input logic         clk,
    input logic         rst_n,
    absmem_seq_if.slave bus
);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);

    state_t        state_q, state_d;
    logic          issue_q, issue_d;
    logic          compare_q, compare_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          timeout_q, timeout_d;
    logic          vacuous_q, vacuous_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic vlg_done;
    logic ila_done;
    logic both_done;
    logic flag_clr;
    logic flag_en;

    // The live commit strobes count too, so the last commit moves straight to COMPARE.
    assign both_done = (vlg_done | bus.vlg_commit) & (ila_done | bus.ila_commit);
    assign flag_en   = (state_q == ST_RUN);

    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        vacuous_d = vacuous_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                if (both_done) begin
                    state_d = ST_COMPARE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_COMPARE: begin
                pass_d  = bus.equal;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!bus.start) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q == ST_RUN || state_q == ST_COMPARE) && !bus.read_assume_true) begin
            vacuous_d = 1'b1;
        end

        // Results are wiped on entry to IDLE or ISSUE so both states present all zeros.
        flag_clr = (state_d == ST_IDLE) || (state_d == ST_ISSUE);
        if (flag_clr) begin
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            vacuous_d = 1'b0;
            cnt_d     = '0;
        end

        issue_d   = (state_d == ST_ISSUE);
        compare_d = (state_d == ST_COMPARE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            issue_q   <= 1'b0;
            compare_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            vacuous_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            issue_q   <= issue_d;
            compare_q <= compare_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            vacuous_q <= vacuous_d;
            cnt_q     <= cnt_d;
        end
    end

    absmem_commit_flag u_vlg_flag (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (flag_clr),
        .en     (flag_en),
        .commit (bus.vlg_commit),
        .done   (vlg_done)
    );

    absmem_commit_flag u_ila_flag (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (flag_clr),
        .en     (flag_en),
        .commit (bus.ila_commit),
        .done   (ila_done)
    );

    assign bus.issue     = issue_q;
    assign bus.compare   = compare_q;
    assign bus.vlg_stall = vlg_done;
    assign bus.ila_stall = ila_done;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.timeout   = timeout_q;
    assign bus.vacuous   = vacuous_q;
    assign bus.cycle_cnt = cnt_q;
endmodule

// File: tb/tb_absmem_seq.sv
// Bench for absmem_seq: directed and random checks predicted from each
// check's commit schedule, plus an asynchronous reset abort.
module tb_absmem_seq;
    localparam int MAXC = 16;
    localparam int CWB  = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    absmem_seq_if #(.CW(CWB)) bus ();

    absmem_seq #(.MAX_CYCLES(MAXC), .CW(CWB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string ph, input bit eIssue, input bit eCompare,
                            input bit eVst, input bit eIst, input bit eDone,
                            input bit ePass, input bit eTo, input bit eVac, input int eCnt);
        checkOutput({ph, ".issue"},     {7'b0, bus.issue},     {7'b0, eIssue});
        checkOutput({ph, ".compare"},   {7'b0, bus.compare},   {7'b0, eCompare});
        checkOutput({ph, ".vlg_stall"}, {7'b0, bus.vlg_stall}, {7'b0, eVst});
        checkOutput({ph, ".ila_stall"}, {7'b0, bus.ila_stall}, {7'b0, eIst});
        checkOutput({ph, ".done"},      {7'b0, bus.done},      {7'b0, eDone});
        checkOutput({ph, ".pass"},      {7'b0, bus.pass},      {7'b0, ePass});
        checkOutput({ph, ".timeout"},   {7'b0, bus.timeout},   {7'b0, eTo});
        checkOutput({ph, ".vacuous"},   {7'b0, bus.vacuous},   {7'b0, eVac});
        checkOutput({ph, ".cycle_cnt"}, {3'b0, bus.cycle_cnt}, 8'(eCnt));
    endtask

    task automatic applyStimulus(input bit s, input bit vc, input bit ac, input bit eq, input bit rat);
        bus.start            = s;
        bus.vlg_commit       = vc;
        bus.ila_commit       = ac;
        bus.equal            = eq;
        bus.read_assume_true = rat;
    endtask

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // vc/ac: RUN cycle of each side's first commit (>= MAXC means never).
    // zeroAt: RUN-relative cycle with read_assume_true=0 (-1 none; endk+1 is COMPARE).
    task automatic runCheck(input int vc, input int ac, input bit eq, input int zeroAt,
                            input int holdCycles, input bit noise);
        int  last;
        int  endk;
        bit  toExp;
        bit  vacExp;
        bit  rat;
        last = (vc > ac) ? vc : ac;
        if (last <= MAXC - 1) begin
            endk  = last;
            toExp = 1'b0;
        end else begin
            endk  = MAXC - 1;
            toExp = 1'b1;
        end

        @(negedge clk);
        checkAll("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1);

        @(negedge clk);
        checkAll("issue", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, noise, noise, 1, !noise);

        vacExp = 1'b0;
        for (int k = 0; k <= endk; k++) begin
            @(negedge clk);
            checkAll("run", 0, 0, vc < k, ac < k, 0, 0, 0, vacExp, k);
            rat = (k == zeroAt) ? 1'b0 : 1'b1;
            applyStimulus(1, (k == vc) || (noise && k > vc && rbit()),
                             (k == ac) || (noise && k > ac && rbit()), rbit(), rat);
            if (!rat) vacExp = 1'b1;
        end

        if (!toExp) begin
            @(negedge clk);
            checkAll("compare", 0, 1, 1, 1, 0, 0, 0, vacExp, endk + 1);
            rat = (zeroAt == endk + 1) ? 1'b0 : 1'b1;
            applyStimulus(1, noise && rbit(), noise && rbit(), eq, rat);
            if (!rat) vacExp = 1'b1;
        end

        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkAll("done", 0, 0, vc <= endk, ac <= endk, 1, toExp ? 1'b0 : eq,
                     toExp, vacExp, endk + 1);
            applyStimulus(h != holdCycles - 1, rbit(), rbit(), rbit(), rbit());
        end
    endtask

    initial begin
        int vcR;
        int acR;
        int endR;
        int zR;
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 1);
        repeat (2) @(negedge clk);
        checkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        runCheck(2, 5, 1, -1, 2, 0);
        runCheck(0, 0, 0, -1, 1, 0);
        runCheck(3, 99, 1, -1, 2, 0);
        runCheck(99, 99, 1, -1, 1, 0);
        runCheck(4, 15, 1, -1, 1, 0);
        runCheck(1, 3, 1, 2, 1, 0);
        runCheck(2, 2, 1, -1, 1, 0);
        runCheck(1, 6, 1, 7, 3, 1);

        // Reset in the middle of RUN, just before both sides would commit.
        @(negedge clk);
        checkAll("rst_pre", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge clk);
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge clk);
        checkAll("rst_run0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 0);
        @(negedge clk);
        checkAll("rst_run1", 0, 0, 1, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 1, 1, 1, 1);
        #2 rst_n = 1'b0;
        #1 checkAll("rst_async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkAll("rst_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        for (int n = 0; n < 30; n++) begin
            vcR  = $urandom_range(0, 20);
            acR  = $urandom_range(0, 20);
            endR = (vcR > acR) ? vcR : acR;
            if (endR > MAXC - 1) endR = MAXC - 1;
            zR   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, endR + 1)) : -1;
            runCheck(vcR, acR, rbit(), zR, $urandom_range(1, 3), rbit());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/absmem_seq.md
# absmem_seq

Check sequencer that drives the control side of the 1R1W abstract memory (`issue`, `compare`) and consumes its results (`equal`, `read_assume_true`). It runs one refinement check at a time:
- pulse `issue` to arm the memory;
- track when the Verilog implementation and the ILA each commit one instruction, and stall each side once it has committed;
- raise `compare` for one cycle and latch the verdict.

It sits between the bench/property layer and the abstract memory instance in each verification wrapper.

## Interface
Parameters:
- MAX_CYCLES, 16: maximum number of RUN cycles allowed before timeout; legal range ≥ 2.
- CW, 5: counter width; must satisfy 2^CW > MAX_CYCLES.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a check; level-sensitive.
- vlg_commit  in  1  Verilog instruction-complete strobe.
- ila_commit  in  1  ILA step-complete strobe.
- equal  in  1  abstract-memory verdict; meaningful only while `compare`=1.
- read_assume_true  in  1  abstract-memory read-consistency condition.
- issue  out  1  one-cycle arm pulse to the abstract memory.
- compare  out  1  one-cycle compare strobe to the abstract memory.
- vlg_stall  out  1  freeze the Verilog side; high after its commit.
- ila_stall  out  1  freeze the ILA side; high after its commit.
- done  out  1  check finished; held in DONE.
- pass  out  1  `equal` as sampled during COMPARE.
- timeout  out  1  MAX_CYCLES elapsed without both commits.
- vacuous  out  1  sticky: `read_assume_true`=0 was seen during RUN or COMPARE.
- cycle_cnt  out  CW  number of RUN cycles elapsed.

## Operation
- States: IDLE, ISSUE, RUN, COMPARE, DONE.
- IDLE: all outputs 0.
  - start=1 → ISSUE.
- ISSUE (exactly 1 cycle): `issue`=1.
  - Clear cycle_cnt, both commit flags, pass, timeout and vacuous.
  - Commits arriving in this cycle are ignored.
  - → RUN.
- RUN:
  - vlg_commit sets vlg_done; ila_commit sets ila_done. Both flags are sticky.
  - A commit on a side whose flag is already set is ignored.
  - vlg_stall = vlg_done (registered); ila_stall = ila_done (registered).
  - cycle_cnt increments by 1 each RUN cycle and saturates at MAX_CYCLES.
  - both_done = (vlg_done | vlg_commit) & (ila_done | ila_commit). This covers same-cycle and cross-cycle commits.
  - both_done → COMPARE.
  - Otherwise, cycle_cnt == MAX_CYCLES-1 → DONE with timeout=1. Commit wins over timeout on the final cycle.
- COMPARE (exactly 1 cycle): `compare`=1; both stalls stay high.
  - pass <= equal.
  - → DONE.
- vacuous is set in any RUN or COMPARE cycle where read_assume_true=0.
- DONE:
  - done=1; pass, timeout, vacuous and cycle_cnt are held.
  - Stalls are held at their last values.
  - start=0 → IDLE. start held at 1 keeps the block in DONE; there is no auto-restart.
- pass and timeout are never both 1.

## Timing
- Reset: asynchronous assert; all outputs 0 and state IDLE immediately. Deassertion is synchronous to clk.
- Reset mid-check aborts the check with no verdict. The abstract memory is reset by its own reset.
- start sampled high at edge t → `issue` high during cycle t+1 → RUN from t+2.
- Both sides commit in RUN cycle k → `compare` high in k+1 → done/pass valid from k+2.
- Fastest check: start to done in 4 cycles.
- Timeout: done=1 at most MAX_CYCLES+2 cycles after ISSUE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `absmem_pkg`:
  - state encoding localparams (IDLE=0, ISSUE=1, RUN=2, COMPARE=3, DONE=4; 3 bits);
  - default MAX_CYCLES.
- Sub-module `absmem_commit_flag`, instantiated twice (Verilog side, ILA side):
  - inputs: clr, en, commit;
  - output: sticky done flag, which also drives the stall.

## Test plan
- start=1; vlg_commit at RUN cycle 2; ila_commit at RUN cycle 5; equal=1 during COMPARE → issue pulse once, vlg_stall from cycle 3, compare one cycle, pass=1, cycle_cnt=6.
- Both commits in the same RUN cycle 0 with equal=0 → compare in the next cycle, pass=0, timeout=0, done 4 cycles after start.
- No ila_commit, MAX_CYCLES=16 → timeout=1 and done=1 after 16 RUN cycles, compare never asserted; the last commit arriving on cycle 15 instead yields COMPARE.
- read_assume_true=0 for one RUN cycle, equal=1 → pass=1 and vacuous=1; a second check (start toggled 1→0→1) clears vacuous.
- rst_n low during RUN → all outputs 0 immediately, IDLE after release, no compare pulse.
- Duplicate vlg_commit in RUN, and commits during the ISSUE cycle → ignored; stall timing unchanged.
